// File: rtl/xgmm_wr_sched.sv
// Memory-side scheduler: drains the XGRI pattern/attribute write FIFOs into VRAM and
// shares the single SDRAM port with display fetch reads.
module xgmm_wr_sched #(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned ATTR_BASE  = 32'h0000_C000,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              p_empty,
  input  logic [15:0]       p_data,
  input  logic [11:0]       par,
  output logic              p_pop,
  input  logic              a_empty,
  input  logic [15:0]       a_data,
  input  logic [12:0]       aar,
  output logic              a_pop,
  input  logic              disp_req,
  input  logic [MEM_AW-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    StIdle, StPIssue, StPPop, StPSettle, StAIssue, StAPop, StASettle, StDIssue
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      p_idx_q, p_idx_d;
  logic            last_wr_q, last_wr_d;  // 1 = attribute write went last
  logic [CntW-1:0] disp_cnt_q, disp_cnt_d;
  logic            wr_pend;
  logic            disp_ok;

  assign wr_pend = ~p_empty | ~a_empty;
  assign disp_ok = disp_cnt_q < CntW'(STARVE_MAX);
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    p_pop     = 1'b0;
    a_pop     = 1'b0;
    disp_gnt  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (disp_req && disp_ok) begin
          state_d = StDIssue;
        end else if (!p_empty && (a_empty || last_wr_q)) begin
          state_d = StPIssue;
        end else if (!a_empty) begin
          state_d = StAIssue;
        end else if (disp_req) begin
          state_d = StDIssue;
        end
      end
      StPIssue: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = MEM_AW'({par, p_idx_q});
        mem_wdata = p_data;
        if (mem_ack) state_d = StPPop;
      end
      StPPop: begin
        p_pop   = 1'b1;
        state_d = StPSettle;
      end
      StPSettle: begin
        // Burst ends on word 3 or when the FIFO runs dry; otherwise keep the port.
        if (p_idx_q == 2'd0 || p_empty) begin
          last_wr_d = 1'b0;
          state_d   = StIdle;
        end else begin
          state_d = StPIssue;
        end
      end
      StAIssue: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = MEM_AW'(ATTR_BASE) + MEM_AW'(aar);
        mem_wdata = a_data;
        if (mem_ack) state_d = StAPop;
      end
      StAPop: begin
        a_pop   = 1'b1;
        state_d = StASettle;
      end
      StASettle: begin
        last_wr_d = 1'b1;
        state_d   = StIdle;
      end
      StDIssue: begin
        mem_req  = 1'b1;
        mem_addr = disp_addr;
        if (mem_ack) begin
          disp_gnt = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    disp_cnt_d = disp_cnt_q;
    if (state_q == StDIssue && mem_ack && wr_pend && disp_cnt_q != CntW'(STARVE_MAX)) begin
      disp_cnt_d = disp_cnt_q + 1'b1;
    end
    // POP always leads into SETTLE, so clearing here is clearing on SETTLE entry.
    if (state_q == StPPop || state_q == StAPop || !wr_pend) begin
      disp_cnt_d = '0;
    end
  end

  always_comb begin
    p_idx_d = p_idx_q;
    if (p_empty) begin
      p_idx_d = 2'd0;
    end else if (state_q == StPPop) begin
      p_idx_d = p_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p_idx_q    <= 2'd0;
      last_wr_q  <= 1'b1;
      disp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      p_idx_q    <= p_idx_d;
      last_wr_q  <= last_wr_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end

endmodule
